// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the 5-stage pipeline.
// Resolves load-use hazards, flushes on EX redirects, freezes on data-memory
// waits, halts on HALT or on a memory-wait timeout, and keeps saturating
// stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       if_id_Rs,
    input  logic [2:0]       if_id_Rt,
    input  logic             if_id_has_Rs,
    input  logic             if_id_has_Rt,
    input  logic [2:0]       id_ex_Rd,
    input  logic             id_ex_wr_en,
    input  logic             id_ex_mem_rd,
    input  logic             ex_redirect,
    input  logic             dmem_stall,
    input  logic             halt_wb,
    output logic             pc_hold,
    output logic             if_id_hold,
    output logic             if_id_flush,
    output logic             id_ex_hold,
    output logic             id_ex_bubble,
    output logic             ex_mem_hold,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_d;
    logic              freeze;
    logic              flush_take;
    logic              lu;

    assign lu = id_ex_mem_rd & id_ex_wr_en &
                ((if_id_has_Rs & (if_id_Rs == id_ex_Rd)) |
                 (if_id_has_Rt & (if_id_Rt == id_ex_Rd)));

    assign halted = (state_q == S_HALT);

    // Next-state, wait counter and pipeline control decode
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        err_d         = err;
        freeze        = 1'b0;
        flush_take    = 1'b0;
        pc_hold       = 1'b0;
        if_id_hold    = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_hold    = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_hold   = 1'b0;
        mem_wb_bubble = 1'b0;

        case (state_q)
            S_RUN, S_MEM_WAIT: begin
                if (dmem_stall) begin
                    freeze  = 1'b1;
                    wait_d  = (state_q == S_RUN) ? WAIT_W'(1) : wait_q + 1'b1;
                    state_d = S_MEM_WAIT;
                    if (halt_wb) begin
                        state_d = S_HALT;
                    end else if (wait_d == WAIT_W'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end
                end else begin
                    // Leaving MEM_WAIT behaves exactly like RUN in the same cycle
                    wait_d  = '0;
                    state_d = halt_wb ? S_HALT : S_RUN;
                    if (ex_redirect) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        flush_take   = 1'b1;
                    end else if (lu) begin
                        pc_hold      = 1'b1;
                        if_id_hold   = 1'b1;
                        id_ex_bubble = 1'b1;
                    end
                end
            end
            S_HALT: begin
                freeze = 1'b1;
            end
            default: begin
                state_d = S_RUN;
                wait_d  = '0;
            end
        endcase

        if (freeze) begin
            pc_hold       = 1'b1;
            if_id_hold    = 1'b1;
            id_ex_hold    = 1'b1;
            ex_mem_hold   = 1'b1;
            mem_wb_bubble = 1'b1;
        end
    end

    // State, wait counter, sticky error and saturating perf counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_RUN;
            wait_q    <= '0;
            err       <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err     <= err_d;
            if (pc_hold && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_take && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: two hazard_ctrl instances (default parameters, and
// TIMEOUT=4/CNT_W=4) driven by shared stimulus and checked against a
// behavioural reference model.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] if_id_Rs, if_id_Rt, id_ex_Rd;
    logic       if_id_has_Rs, if_id_has_Rt, id_ex_wr_en, id_ex_mem_rd;
    logic       ex_redirect, dmem_stall, halt_wb;

    logic        pc_hold_a, if_id_hold_a, if_id_flush_a, id_ex_hold_a;
    logic        id_ex_bubble_a, ex_mem_hold_a, mem_wb_bubble_a, halted_a, err_a;
    logic [15:0] stall_cnt_a, flush_cnt_a;
    logic        pc_hold_b, if_id_hold_b, if_id_flush_b, id_ex_hold_b;
    logic        id_ex_bubble_b, ex_mem_hold_b, mem_wb_bubble_b, halted_b, err_b;
    logic [3:0]  stall_cnt_b, flush_cnt_b;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] C_IDLE   = 7'b0000000;
    localparam logic [6:0] C_LU     = 7'b1100100;
    localparam logic [6:0] C_REDIR  = 7'b0010100;
    localparam logic [6:0] C_FREEZE = 7'b1101011;

    hazard_ctrl dut_a (
        .clk(clk), .rst(rst),
        .if_id_Rs(if_id_Rs), .if_id_Rt(if_id_Rt),
        .if_id_has_Rs(if_id_has_Rs), .if_id_has_Rt(if_id_has_Rt),
        .id_ex_Rd(id_ex_Rd), .id_ex_wr_en(id_ex_wr_en), .id_ex_mem_rd(id_ex_mem_rd),
        .ex_redirect(ex_redirect), .dmem_stall(dmem_stall), .halt_wb(halt_wb),
        .pc_hold(pc_hold_a), .if_id_hold(if_id_hold_a), .if_id_flush(if_id_flush_a),
        .id_ex_hold(id_ex_hold_a), .id_ex_bubble(id_ex_bubble_a),
        .ex_mem_hold(ex_mem_hold_a), .mem_wb_bubble(mem_wb_bubble_a),
        .halted(halted_a), .err(err_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
    );

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .if_id_Rs(if_id_Rs), .if_id_Rt(if_id_Rt),
        .if_id_has_Rs(if_id_has_Rs), .if_id_has_Rt(if_id_has_Rt),
        .id_ex_Rd(id_ex_Rd), .id_ex_wr_en(id_ex_wr_en), .id_ex_mem_rd(id_ex_mem_rd),
        .ex_redirect(ex_redirect), .dmem_stall(dmem_stall), .halt_wb(halt_wb),
        .pc_hold(pc_hold_b), .if_id_hold(if_id_hold_b), .if_id_flush(if_id_flush_b),
        .id_ex_hold(id_ex_hold_b), .id_ex_bubble(id_ex_bubble_b),
        .ex_mem_hold(ex_mem_hold_b), .mem_wb_bubble(mem_wb_bubble_b),
        .halted(halted_b), .err(err_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    // Observed outputs gathered per instance: index 0 = dut_a, 1 = dut_b
    logic [6:0]  ctl_o[2];
    logic        halted_o[2], err_o[2];
    logic [15:0] stall_o[2], flush_o[2];
    assign ctl_o[0]    = {pc_hold_a, if_id_hold_a, if_id_flush_a, id_ex_hold_a,
                          id_ex_bubble_a, ex_mem_hold_a, mem_wb_bubble_a};
    assign ctl_o[1]    = {pc_hold_b, if_id_hold_b, if_id_flush_b, id_ex_hold_b,
                          id_ex_bubble_b, ex_mem_hold_b, mem_wb_bubble_b};
    assign halted_o[0] = halted_a;
    assign halted_o[1] = halted_b;
    assign err_o[0]    = err_a;
    assign err_o[1]    = err_b;
    assign stall_o[0]  = stall_cnt_a;
    assign stall_o[1]  = {12'b0, stall_cnt_b};
    assign flush_o[0]  = flush_cnt_a;
    assign flush_o[1]  = {12'b0, flush_cnt_b};

    // Reference model: a halted flag, a run of consecutive wait cycles, and counts
    int unsigned to_p[2] = '{64, 4};
    int unsigned cmax[2] = '{65535, 15};
    bit          m_halted[2];
    bit          m_err[2];
    int unsigned m_wait[2];
    int unsigned m_stall[2];
    int unsigned m_flush[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] model_ctl(input int i);
        bit hit;
        hit = id_ex_mem_rd && id_ex_wr_en &&
              ((if_id_has_Rs && if_id_Rs == id_ex_Rd) || (if_id_has_Rt && if_id_Rt == id_ex_Rd));
        if (m_halted[i] || dmem_stall) return C_FREEZE;
        if (ex_redirect)               return C_REDIR;
        if (hit)                       return C_LU;
        return C_IDLE;
    endfunction

    task automatic model_step();
        logic [6:0] c;
        for (int i = 0; i < 2; i++) begin
            c = model_ctl(i);
            if (!rst) begin
                m_halted[i] = 0; m_err[i] = 0; m_wait[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
            end else begin
                if (c[6] && m_stall[i] < cmax[i]) m_stall[i]++;
                if (c[4] && m_flush[i] < cmax[i]) m_flush[i]++;
                if (!m_halted[i]) begin
                    if (halt_wb) begin
                        m_halted[i] = 1;
                    end else if (dmem_stall) begin
                        m_wait[i]++;
                        if (m_wait[i] == to_p[i]) begin
                            m_halted[i] = 1;
                            m_err[i]    = 1;
                        end
                    end else begin
                        m_wait[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        if_id_Rs = 3'd0; if_id_Rt = 3'd0; id_ex_Rd = 3'd0;
        if_id_has_Rs = 0; if_id_has_Rt = 0; id_ex_wr_en = 0; id_ex_mem_rd = 0;
        ex_redirect = 0; dmem_stall = 0; halt_wb = 0;
    endtask

    task automatic set_lu(input bit use_rt, input bit has);
        set_idle();
        id_ex_mem_rd = 1; id_ex_wr_en = 1; id_ex_Rd = 3'd3;
        if (use_rt) begin if_id_Rt = 3'd3; if_id_has_Rt = has; if_id_Rs = 3'd5; if_id_has_Rs = 1; end
        else        begin if_id_Rs = 3'd3; if_id_has_Rs = has; end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        set_idle();
        rst = 0;
        advance();
        rst = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ctl_o[i] !== C_IDLE || halted_o[i] !== 1'b0 || err_o[i] !== 1'b0 ||
                stall_o[i] !== 16'd0 || flush_o[i] !== 16'd0) begin
                errors++;
                $display("FAIL reset[%0d] got ctl=%b halted=%b err=%b stall=%0d flush=%0d required 0000000/0/0/0/0",
                         i, ctl_o[i], halted_o[i], err_o[i], stall_o[i], flush_o[i]);
            end
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        @(negedge clk); set_lu(0, 1); #1;
        checks++;
        if (ctl_o[0] !== C_LU) begin errors++; $display("FAIL lu_rs ctl got %b required %b", ctl_o[0], C_LU); end
        advance();
        checks++;
        if (stall_o[0] !== 16'd1) begin errors++; $display("FAIL lu_rs stall_cnt got %0d required 1", stall_o[0]); end
        @(negedge clk); set_idle(); #1;
        checks++;
        if (ctl_o[0] !== C_IDLE) begin errors++; $display("FAIL lu_one_cycle ctl got %b required %b", ctl_o[0], C_IDLE); end
        advance();
        @(negedge clk); set_lu(0, 0); #1;
        checks++;
        if (ctl_o[0] !== C_IDLE) begin errors++; $display("FAIL lu_no_has_rs ctl got %b required %b", ctl_o[0], C_IDLE); end
        advance();
        @(negedge clk); set_lu(1, 1); #1;
        checks++;
        if (ctl_o[0] !== C_LU) begin errors++; $display("FAIL lu_rt ctl got %b required %b", ctl_o[0], C_LU); end
        advance();
        checks++;
        if (stall_o[0] !== 16'd2) begin errors++; $display("FAIL lu_total stall_cnt got %0d required 2", stall_o[0]); end
    endtask

    task automatic test_redirect_vs_lu();
        apply_reset();
        @(negedge clk); set_lu(0, 1); ex_redirect = 1; #1;
        checks++;
        if (ctl_o[0] !== C_REDIR) begin errors++; $display("FAIL redir_lu ctl got %b required %b", ctl_o[0], C_REDIR); end
        advance();
        checks++;
        if (flush_o[0] !== 16'd1 || stall_o[0] !== 16'd0) begin
            errors++;
            $display("FAIL redir_lu counters got flush=%0d stall=%0d required 1/0", flush_o[0], stall_o[0]);
        end
    endtask

    task automatic test_mem_stall();
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); set_idle(); dmem_stall = 1; #1;
            checks++;
            if (ctl_o[0] !== C_FREEZE) begin errors++; $display("FAIL mem_stall[%0d] ctl got %b required %b", k, ctl_o[0], C_FREEZE); end
            advance();
        end
        @(negedge clk); set_idle(); #1;
        checks++;
        if (ctl_o[0] !== C_IDLE) begin errors++; $display("FAIL mem_release ctl got %b required %b", ctl_o[0], C_IDLE); end
        advance();
        checks++;
        if (stall_o[0] !== 16'd5 || err_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL mem_stall_cnt got stall=%0d err=%b required 5/0", stall_o[0], err_o[0]);
        end
        // leaving the wait with a redirect present must flush in that same cycle
        @(negedge clk); set_idle(); dmem_stall = 1; advance();
        @(negedge clk); set_idle(); ex_redirect = 1; #1;
        checks++;
        if (ctl_o[0] !== C_REDIR) begin errors++; $display("FAIL mem_exit_redir ctl got %b required %b", ctl_o[0], C_REDIR); end
        advance();
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); set_idle(); dmem_stall = 1; #1;
            checks++;
            if (ctl_o[1] !== C_FREEZE) begin errors++; $display("FAIL to_ctl[%0d] got %b required %b", k, ctl_o[1], C_FREEZE); end
            advance();
            checks++;
            if (err_o[1] !== (k == 4) || halted_o[1] !== (k == 4)) begin
                errors++;
                $display("FAIL to_err[%0d] got err=%b halted=%b required %0d/%0d", k, err_o[1], halted_o[1], k == 4, k == 4);
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); set_idle(); ex_redirect = 1; #1;
            checks++;
            if (ctl_o[1] !== C_FREEZE) begin errors++; $display("FAIL to_halt_ctl[%0d] got %b required %b", k, ctl_o[1], C_FREEZE); end
            advance();
        end
        checks++;
        if (halted_o[1] !== 1'b1 || err_o[1] !== 1'b1 || stall_o[1] !== 16'd7 || flush_o[1] !== 16'd0) begin
            errors++;
            $display("FAIL to_sticky got halted=%b err=%b stall=%0d flush=%0d required 1/1/7/0",
                     halted_o[1], err_o[1], stall_o[1], flush_o[1]);
        end
        checks++;
        if (halted_o[0] !== 1'b0 || err_o[0] !== 1'b0 || stall_o[0] !== 16'd4 || flush_o[0] !== 16'd3) begin
            errors++;
            $display("FAIL to_dflt got halted=%b err=%b stall=%0d flush=%0d required 0/0/4/3",
                     halted_o[0], err_o[0], stall_o[0], flush_o[0]);
        end
        apply_reset();
        checks++;
        if (halted_o[1] !== 1'b0 || err_o[1] !== 1'b0 || stall_o[1] !== 16'd0 || flush_o[1] !== 16'd0) begin
            errors++;
            $display("FAIL to_reset got halted=%b err=%b stall=%0d flush=%0d required 0/0/0/0",
                     halted_o[1], err_o[1], stall_o[1], flush_o[1]);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        @(negedge clk); set_idle(); halt_wb = 1; #1;
        checks++;
        if (ctl_o[0] !== C_IDLE || halted_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL halt_entry got ctl=%b halted=%b required %b/0", ctl_o[0], halted_o[0], C_IDLE);
        end
        advance();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin set_idle(); ex_redirect = 1; end
            else set_lu(0, 1);
            #1;
            checks++;
            if (ctl_o[0] !== C_FREEZE || halted_o[0] !== 1'b1) begin
                errors++;
                $display("FAIL halt_frozen[%0d] got ctl=%b halted=%b required %b/1", k, ctl_o[0], halted_o[0], C_FREEZE);
            end
            advance();
        end
        checks++;
        if (flush_o[0] !== 16'd0 || stall_o[0] !== 16'd4 || err_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL halt_counters got flush=%0d stall=%0d err=%b required 0/4/0", flush_o[0], stall_o[0], err_o[0]);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); set_lu(0, 1); advance();
            @(negedge clk); set_idle(); advance();
        end
        checks++;
        if (stall_o[1] !== 16'd15 || stall_o[0] !== 16'd20) begin
            errors++;
            $display("FAIL saturation got b=%0d a=%0d required 15/20", stall_o[1], stall_o[0]);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if_id_Rs     = 3'($urandom_range(0, 3));
            if_id_Rt     = 3'($urandom_range(0, 3));
            id_ex_Rd     = 3'($urandom_range(0, 3));
            if_id_has_Rs = 1'($urandom_range(0, 1));
            if_id_has_Rt = 1'($urandom_range(0, 1));
            id_ex_wr_en  = ($urandom_range(0, 3) != 0);
            id_ex_mem_rd = ($urandom_range(0, 1) != 0);
            ex_redirect  = ($urandom_range(0, 3) == 0);
            dmem_stall   = ($urandom_range(0, 2) == 0);
            halt_wb      = ($urandom_range(0, 79) == 0);
            rst          = ($urandom_range(0, 39) != 0);
            #1;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (ctl_o[i] !== model_ctl(i) || halted_o[i] !== m_halted[i]) begin
                    errors++;
                    $display("FAIL rand_ctl[%0d] cyc %0d got ctl=%b halted=%b required %b/%0d",
                             i, n, ctl_o[i], halted_o[i], model_ctl(i), m_halted[i]);
                end
            end
            advance();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (err_o[i] !== m_err[i] || stall_o[i] !== 16'(m_stall[i]) || flush_o[i] !== 16'(m_flush[i])) begin
                    errors++;
                    $display("FAIL rand_regs[%0d] cyc %0d got err=%b stall=%0d flush=%0d required %0d/%0d/%0d",
                             i, n, err_o[i], stall_o[i], flush_o[i], m_err[i], m_stall[i], m_flush[i]);
                end
            end
        end
        rst = 1;
    endtask

    initial begin
        rst = 1;
        set_idle();
        for (int i = 0; i < 2; i++) begin
            m_halted[i] = 0; m_err[i] = 0; m_wait[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
        end
        test_reset();
        test_load_use();
        test_redirect_vs_lu();
        test_mem_stall();
        test_timeout();
        test_halt();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
